// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-port responder.
// Imported by the interface, array and responder FSM.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_DONE = 2'd3
    } mem_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath and the memory responder.
// master = control/datapath side, slave = memory side.
interface mem_responder_if;

    logic        req;
    logic        wr;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData;
    logic        busy;
    logic        rd_valid;
    logic        wr_ack;
    logic        err;

    modport master (
        output req, wr, Address, WriteData,
        input  MemData, busy, rd_valid, wr_ack, err
    );

    modport slave (
        input  req, wr, Address, WriteData,
        output MemData, busy, rd_valid, wr_ack, err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, asynchronous read, no reset.
// Contents survive responder reset by design.
module mem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: fault check, read-latency counter and
// completion pulses for the multicycle control FSM.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LAT      = 3
) (
    input  logic            Clk,
    input  logic            Reset_signal,
    mem_responder_if.slave  bus
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int OFS = $clog2(WORD_BYTES);

    localparam logic [3:0] CNT_INIT =
        (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    mem_state_t  state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [31:0] hold_q, hold_n;
    logic [31:0] data_q, data_n;
    logic        flt_q, flt_n;
    logic        busy_q, rd_valid_q, wr_ack_q, err_q;

    logic          accept;
    logic          fault;
    logic          we;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;

    assign idx = bus.Address[AW+OFS-1:OFS];

    // Power-of-two depth: any set bit above the index field is out of range.
    assign fault = ((bus.Address[1:0] & ALIGN_MASK) != 2'b00)
                 || (|bus.Address[31:AW+OFS]);

    assign accept = bus.req & ~busy_q;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .Clk   (Clk),
        .we    (we & ~Reset_signal),
        .idx   (idx),
        .wdata (bus.WriteData),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        hold_n  = hold_q;
        data_n  = data_q;
        flt_n   = flt_q;
        we      = 1'b0;
        unique case (state_q)
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_n = RD_DONE;
                    data_n  = hold_q;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                if (accept) begin
                    flt_n = fault;
                    if (bus.wr) begin
                        we      = ~fault;
                        state_n = WR_DONE;
                    end else begin
                        hold_n = fault ? 32'd0 : rdata;
                        if (RD_LAT == 1) begin
                            state_n = RD_DONE;
                            data_n  = hold_n;
                        end else begin
                            state_n = RD_WAIT;
                            cnt_n   = CNT_INIT;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            hold_q     <= 32'd0;
            data_q     <= 32'd0;
            flt_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            hold_q     <= hold_n;
            data_q     <= data_n;
            flt_q      <= flt_n;
            busy_q     <= (state_n == RD_WAIT);
            rd_valid_q <= (state_n == RD_DONE);
            wr_ack_q   <= (state_n == WR_DONE);
            err_q      <= flt_n &&
                          (state_n == RD_DONE || state_n == WR_DONE);
        end
    end

    assign bus.MemData  = data_q;
    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RD_LAT=3 and RD_LAT=1 builds.
// Outputs checked 1ns after each rising edge; o = {busy,rd_valid,wr_ack,err}.
module tb_mem_responder;

    logic Clk = 1'b0;
    logic Reset_signal = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    mem_responder #(.DEPTH_WORDS(256), .RD_LAT(3)) dut0 (
        .Clk          (Clk),
        .Reset_signal (Reset_signal),
        .bus          (bus0)
    );

    mem_responder #(.DEPTH_WORDS(256), .RD_LAT(1)) dut1 (
        .Clk          (Clk),
        .Reset_signal (Reset_signal),
        .bus          (bus1)
    );

    logic [3:0] o0, o1;
    assign o0 = {bus0.busy, bus0.rd_valid, bus0.wr_ack, bus0.err};
    assign o1 = {bus1.busy, bus1.rd_valid, bus1.wr_ack, bus1.err};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req0(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
        bus0.req = 1'b1;
        bus0.wr = w;
        bus0.Address = a;
        bus0.WriteData = d;
    endtask

    task automatic idle0();
        bus0.req = 1'b0;
        bus0.wr = 1'b0;
    endtask

    task automatic test_reset();
        Reset_signal = 1'b1;
        tick();
        tick();
        Reset_signal = 1'b0;
        checks++;
        if (o0 !== 4'b0000 || bus0.MemData !== 32'd0) begin
            failures++;
            $display("FAIL reset0 got o=%b data=%h want o=0000 data=0",
                     o0, bus0.MemData);
        end
        checks++;
        if (o1 !== 4'b0000 || bus1.MemData !== 32'd0) begin
            failures++;
            $display("FAIL reset1 got o=%b data=%h want o=0000 data=0",
                     o1, bus1.MemData);
        end
    endtask

    task automatic test_write_read();
        req0(1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        idle0();
        checks++;
        if (o0 !== 4'b0010) begin
            failures++;
            $display("FAIL wr_ack got o=%b want 0010", o0);
        end
        tick();
        checks++;
        if (o0 !== 4'b0000) begin
            failures++;
            $display("FAIL wr_ack_pulse got o=%b want 0000", o0);
        end
        req0(1'b0, 32'h10, 32'h0);
        tick();
        idle0();
        checks++;
        if (o0 !== 4'b1000) begin
            failures++;
            $display("FAIL rd_busy1 got o=%b want 1000", o0);
        end
        tick();
        checks++;
        if (o0 !== 4'b1000) begin
            failures++;
            $display("FAIL rd_busy2 got o=%b want 1000", o0);
        end
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_done got o=%b data=%h want 0100 deadbeef",
                     o0, bus0.MemData);
        end
        tick();
        checks++;
        if (o0 !== 4'b0000 || bus0.MemData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_hold got o=%b data=%h want 0000 deadbeef",
                     o0, bus0.MemData);
        end
    endtask

    task automatic test_back_to_back();
        req0(1'b1, 32'h20, 32'h12345678);
        tick();
        req0(1'b0, 32'h20, 32'h0);
        tick();
        idle0();
        checks++;
        if (o0 !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_accept got o=%b want 1000", o0);
        end
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_raw got o=%b data=%h want 0100 12345678",
                     o0, bus0.MemData);
        end
        req0(1'b0, 32'h10, 32'h0);
        tick();
        idle0();
        checks++;
        if (o0 !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_nobubble got o=%b want 1000", o0);
        end
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL b2b_second got o=%b data=%h want 0100 deadbeef",
                     o0, bus0.MemData);
        end
        tick();
    endtask

    task automatic test_faults();
        req0(1'b1, 32'h0, 32'hA5A5A5A5);
        tick();
        idle0();
        tick();
        req0(1'b0, 32'h13, 32'h0);
        tick();
        idle0();
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0101 || bus0.MemData !== 32'd0) begin
            failures++;
            $display("FAIL flt_rd got o=%b data=%h want 0101 0",
                     o0, bus0.MemData);
        end
        req0(1'b1, 32'h400, 32'hCAFEF00D);
        tick();
        idle0();
        checks++;
        if (o0 !== 4'b0011) begin
            failures++;
            $display("FAIL flt_wr got o=%b want 0011", o0);
        end
        tick();
        req0(1'b0, 32'h0, 32'h0);
        tick();
        idle0();
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL flt_alias got o=%b data=%h want 0100 a5a5a5a5",
                     o0, bus0.MemData);
        end
        tick();
    endtask

    task automatic test_busy_drop();
        req0(1'b0, 32'h10, 32'h0);
        tick();
        idle0();
        req0(1'b0, 32'h20, 32'h0);
        tick();
        idle0();
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL busy_first got o=%b data=%h want 0100 deadbeef",
                     o0, bus0.MemData);
        end
        tick();
        checks++;
        if (o0 !== 4'b0000) begin
            failures++;
            $display("FAIL busy_drop got o=%b want 0000", o0);
        end
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0000 || bus0.MemData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL busy_quiet got o=%b data=%h want 0000 deadbeef",
                     o0, bus0.MemData);
        end
    endtask

    task automatic test_reset_mid_read();
        req0(1'b0, 32'h20, 32'h0);
        tick();
        idle0();
        Reset_signal = 1'b1;
        tick();
        Reset_signal = 1'b0;
        checks++;
        if (o0 !== 4'b0000 || bus0.MemData !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got o=%b data=%h want 0000 0",
                     o0, bus0.MemData);
        end
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0000) begin
            failures++;
            $display("FAIL rst_norv got o=%b want 0000", o0);
        end
        req0(1'b1, 32'h20, 32'hFFFF0000);
        Reset_signal = 1'b1;
        tick();
        Reset_signal = 1'b0;
        idle0();
        checks++;
        if (o0 !== 4'b0000) begin
            failures++;
            $display("FAIL rst_wr got o=%b want 0000", o0);
        end
        req0(1'b0, 32'h20, 32'h0);
        tick();
        idle0();
        tick();
        tick();
        checks++;
        if (o0 !== 4'b0100 || bus0.MemData !== 32'h12345678) begin
            failures++;
            $display("FAIL rst_keep got o=%b data=%h want 0100 12345678",
                     o0, bus0.MemData);
        end
        tick();
    endtask

    task automatic test_lat1();
        bus1.req = 1'b1;
        bus1.wr = 1'b1;
        bus1.Address = 32'h10;
        bus1.WriteData = 32'h0BADF00D;
        tick();
        bus1.wr = 1'b0;
        tick();
        bus1.req = 1'b0;
        checks++;
        if (o1 !== 4'b0100 || bus1.MemData !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL lat1_rd got o=%b data=%h want 0100 0badf00d",
                     o1, bus1.MemData);
        end
        tick();
        checks++;
        if (o1 !== 4'b0000 || bus1.MemData !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL lat1_idle got o=%b data=%h want 0000 0badf00d",
                     o1, bus1.MemData);
        end
    endtask

    initial begin
        bus0.req = 1'b0;
        bus0.wr = 1'b0;
        bus0.Address = 32'h0;
        bus0.WriteData = 32'h0;
        bus1.req = 1'b0;
        bus1.wr = 1'b0;
        bus1.Address = 32'h0;
        bus1.WriteData = 32'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_faults();
        test_busy_drop();
        test_reset_mid_read();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath's memory port.
- Accepts single-word read/write requests from the control/datapath side and returns read data after a fixed, parameterised latency.
- Gives the control FSM a deterministic completion signal to wait on, so it no longer counts fixed delay states.
- Sits between the IorD address mux / B-register write data and the MDR/IR load path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two).
- RD_LAT, 3, cycles from the request-acceptance edge to the rd_valid pulse; legal range 1..15.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Reset_signal  in  1  synchronous, active-high reset.
- req  in  1  request strobe; accepted when req=1 and busy=0 at a rising edge.
- wr  in  1  1 = write, 0 = read; sampled at acceptance.
- Address  in  32  byte address; sampled at acceptance.
- WriteData  in  32  write word; sampled at acceptance.
- MemData  out  32  read data; valid while rd_valid=1, held until the next read completes.
- busy  out  1  registered; 1 while a read is in flight and requests are ignored.
- rd_valid  out  1  one-cycle pulse marking read completion.
- wr_ack  out  1  one-cycle pulse, the cycle after write acceptance.
- err  out  1  one-cycle pulse, with the rd_valid or wr_ack of a faulted request.

Behaviour:
- Clock and reset: one clock, Clk. Reset_signal is synchronous and active-high.
- Reset values: state=IDLE, counter=0, MemData=0, busy=0, rd_valid=0, wr_ack=0, err=0.
- Reset does not alter array contents.
- States: IDLE, RD_WAIT, RD_DONE, WR_DONE.
- Acceptance: accept = req & ~busy. A req seen while busy=1 is ignored (no queue). The initiator holds req until acceptance and drops it the cycle after.
- Fault check at acceptance: fault if Address[1:0]!=0 or Address[31:2] >= DEPTH_WORDS. A faulted request never touches the array.
- Word index is Address[$clog2(DEPTH_WORDS)+1:2].
- Read acceptance, RD_LAT=1: the array word is captured into the holding register; next state is RD_DONE.
- Read acceptance, RD_LAT>1: the array word is captured into the holding register; counter=RD_LAT-2; next state is RD_WAIT.
- RD_WAIT: busy=1. Count down; when counter=0, go to RD_DONE.
- RD_DONE: rd_valid=1, MemData=captured word, busy=0. A new request may be accepted in this same cycle.
- Timing: rd_valid asserts exactly RD_LAT cycles after the acceptance edge. busy is high for RD_LAT-1 cycles.
- Write acceptance: the array word is written at the acceptance edge. Next state is WR_DONE with wr_ack=1, busy=0. Back-to-back requests are allowed.
- Faulted read: RD_DONE is reached with the normal latency; MemData=0, err=1.
- Faulted write: WR_DONE with err=1; no array write.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at N+1 returns the new data.
- Read data reflects the array at the read-acceptance edge.
- MemData holds its last valid value outside RD_DONE. It changes only on read completion or reset.
- Reset mid-read: the in-flight read is discarded; no rd_valid is emitted; the state returns to IDLE next cycle.
- Reset on a write-acceptance edge: reset wins and the write is not committed.
- rd_valid, wr_ack and err are never high in IDLE or RD_WAIT.

Decomposition:
- Package mem_pkg:
  - state enum mem_state_t {IDLE, RD_WAIT, RD_DONE, WR_DONE};
  - WORD_BYTES=4;
  - ALIGN_MASK=2'b11.
- Sub-module mem_array:
  - single port, DEPTH_WORDS x 32;
  - synchronous write, asynchronous read;
  - no reset.
- The FSM, counter and fault check stay in mem_responder.

Test Plan:
- Write then read, RD_LAT=3: write 0xDEADBEEF at 0x10 (req one cycle) -> wr_ack=1 next cycle, err=0. Read 0x10 -> busy=1 for 2 cycles, rd_valid=1 exactly 3 cycles after acceptance, MemData=0xDEADBEEF.
- Back-to-back: write 0x12345678 at 0x20, read 0x20 on the following cycle -> MemData=0x12345678. Then a read issued in the RD_DONE cycle -> accepted with no bubble.
- Faults: read 0x13 -> rd_valid with err=1, MemData=0. Write to byte address 4*DEPTH_WORDS (0x400 at default) -> wr_ack with err=1. Reading that word's alias address 0x0 afterwards -> contents unchanged.
- Busy drop: issue a read, then pulse req for a different address while busy=1 -> second request ignored; only one rd_valid, carrying the first address's data.
- Reset mid-read: assert Reset_signal one cycle into RD_WAIT -> no rd_valid, all outputs 0 next cycle. A later read of a previously written word returns the old value (array preserved).
- RD_LAT=1 build: read 0x10 -> rd_valid the cycle after acceptance, busy never asserted.
